// File: rtl/cpu_pkg.sv
// Shared constants and Tuse/Tnew helpers for the five-stage MIPS core.
// The hazard check below is used once per source operand and pipeline stage.
package cpu_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam logic [31:0] EXC_HANDLER_PC  = 32'h0000_4180;
  localparam logic [31:0] RESET_PC        = 32'h0000_3000;

  typedef logic [1:0] tuse_t;
  localparam tuse_t TUSE_NONE = 2'd3;

  // A TUSE_NONE operand can never stall: tnew is at most 3, and 3 is not greater than 3.
  function automatic logic reg_hazard(input logic [4:0] src, input tuse_t tuse,
                                      input logic [4:0] a3, input tuse_t tnew);
    return (src != 5'd0) && (a3 == src) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy countdown for the multiply/divide unit, loaded when an md op issues from E.
// The issue cycle itself reports busy.
module md_busy_counter
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             req,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A start alongside Req belongs to a squashed instruction; an older countdown keeps running.
  always_comb begin
    count_d = count_q;
    if (start && !req) begin
      count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy  = start | (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble decision for the D/E pipeline registers from Tuse/Tnew hazards and
// md-unit occupancy; an exception request overrides any stall.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [1:0]        D_tuse_rs,
  input  logic [1:0]        D_tuse_rt,
  input  logic              D_is_md,
  input  logic [4:0]        E_A3,
  input  logic [1:0]        E_tnew,
  input  logic [4:0]        M_A3,
  input  logic [1:0]        M_tnew,
  input  logic              E_md_start,
  input  logic              E_md_div,
  input  logic              Req,
  output logic              D_stall,
  output logic              E_flush,
  output logic              md_busy,
  output logic [CNT_W-1:0]  md_count,
  output logic [PERF_W-1:0] stall_cycles
);

  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              stall;
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_div),
    .req    (Req),
    .busy   (md_busy),
    .count  (md_count)
  );

  always_comb begin
    stall_rs = reg_hazard(D_rs, D_tuse_rs, E_A3, E_tnew) |
               reg_hazard(D_rs, D_tuse_rs, M_A3, M_tnew);
    stall_rt = reg_hazard(D_rt, D_tuse_rt, E_A3, E_tnew) |
               reg_hazard(D_rt, D_tuse_rt, M_A3, M_tnew);
    stall_md = D_is_md & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
    D_stall  = stall & ~Req;
    E_flush  = stall & ~Req;
  end

  // Saturate instead of wrapping so a long run never reports a tiny stall count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (D_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_div, Req;
  logic        D_stall, E_flush, md_busy;
  logic [3:0]  md_count;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_perf;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .D_rs         (D_rs),
    .D_rt         (D_rt),
    .D_tuse_rs    (D_tuse_rs),
    .D_tuse_rt    (D_tuse_rt),
    .D_is_md      (D_is_md),
    .E_A3         (E_A3),
    .E_tnew       (E_tnew),
    .M_A3         (M_A3),
    .M_tnew       (M_tnew),
    .E_md_start   (E_md_start),
    .E_md_div     (E_md_div),
    .Req          (Req),
    .D_stall      (D_stall),
    .E_flush      (E_flush),
    .md_busy      (md_busy),
    .md_count     (md_count),
    .stall_cycles (stall_cycles)
  );

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
    E_A3 = 5'd0; E_tnew = 2'd0; M_A3 = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0; Req = 1'b0;
  endtask

  // Advance one clock and leave time 1ns past the edge, ready to drive inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    #1;
    n_checks++;
    if (md_count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_md_count got %0d want 0", md_count); end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_perf got %0d want 0", stall_cycles); end
    n_checks++;
    if ({D_stall, E_flush, md_busy} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_outputs got %b want 000", {D_stall, E_flush, md_busy});
    end
    reset = 1'b0;
    tick();
    exp_perf = 16'd0;
  endtask

  task automatic test_load_use();
    E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
    #1;
    n_checks++;
    if ({D_stall, E_flush} !== 2'b11) begin n_fail++; $display("[TB] FAIL load_use_stall got %b want 11", {D_stall, E_flush}); end
    tick();
    exp_perf = exp_perf + 16'd1;
    E_tnew = 2'd1; M_A3 = 5'd8; M_tnew = 2'd1;
    #1;
    n_checks++;
    if ({D_stall, E_flush} !== 2'b00) begin n_fail++; $display("[TB] FAIL load_use_release got %b want 00", {D_stall, E_flush}); end
    n_checks++;
    if (stall_cycles !== exp_perf) begin n_fail++; $display("[TB] FAIL load_use_perf got %0d want %0d", stall_cycles, exp_perf); end
    tick();
    // rt operand hazard via M stage: tnew 1 > tuse 0.
    idle_inputs();
    M_A3 = 5'd9; M_tnew = 2'd1; D_rt = 5'd9; D_tuse_rt = 2'd0;
    #1;
    n_checks++;
    if (D_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rt_m_stall got %b want 1", D_stall); end
    // Same hazard with Req: exception flush wins.
    Req = 1'b1;
    #1;
    n_checks++;
    if ({D_stall, E_flush} !== 2'b00) begin n_fail++; $display("[TB] FAIL req_override got %b want 00", {D_stall, E_flush}); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cycles !== exp_perf) begin n_fail++; $display("[TB] FAIL req_perf got %0d want %0d", stall_cycles, exp_perf); end
    tick();
  endtask

  task automatic test_zero_reg();
    E_A3 = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0;
    M_A3 = 5'd0; M_tnew = 2'd2; D_rt = 5'd0; D_tuse_rt = 2'd0;
    #1;
    n_checks++;
    if (D_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_reg_stall got %b want 0", D_stall); end
    tick();
    n_checks++;
    if (stall_cycles !== exp_perf) begin n_fail++; $display("[TB] FAIL zero_reg_perf got %0d want %0d", stall_cycles, exp_perf); end
    idle_inputs();
    tick();
  endtask

  task automatic test_mult_busy();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
    #1;
    n_checks++;
    if ({D_stall, md_busy} !== 2'b11) begin n_fail++; $display("[TB] FAIL mult_issue got %b want 11", {D_stall, md_busy}); end
    tick();
    exp_perf = exp_perf + 16'd1;
    E_md_start = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      #1;
      n_checks++;
      if (md_count !== 4'(k) || D_stall !== 1'b1) begin
        n_fail++; $display("[TB] FAIL mult_count got cnt=%0d stall=%b want cnt=%0d stall=1", md_count, D_stall, k);
      end
      tick();
      exp_perf = exp_perf + 16'd1;
    end
    #1;
    n_checks++;
    if (md_count !== 4'd0 || D_stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mult_done got cnt=%0d stall=%b busy=%b want 0 0 0", md_count, D_stall, md_busy);
    end
    n_checks++;
    if (stall_cycles !== exp_perf) begin n_fail++; $display("[TB] FAIL mult_perf got %0d want %0d", stall_cycles, exp_perf); end
    idle_inputs();
    tick();
  endtask

  task automatic test_div_req();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1; Req = 1'b1;
    #1;
    n_checks++;
    if ({D_stall, E_flush} !== 2'b00) begin n_fail++; $display("[TB] FAIL div_req_outputs got %b want 00", {D_stall, E_flush}); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (md_count !== 4'd0 || md_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL div_req_count got cnt=%0d busy=%b want 0 0", md_count, md_busy);
    end
    tick();
    // A mult already counting keeps going through a later Req.
    E_md_start = 1'b1;
    tick();
    E_md_start = 1'b0; Req = 1'b1;
    tick();
    Req = 1'b0;
    #1;
    n_checks++;
    if (md_count !== 4'd4) begin n_fail++; $display("[TB] FAIL inflight_req got %0d want 4", md_count); end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset_mid_div();
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    #1;
    n_checks++;
    if (md_count !== 4'd7) begin n_fail++; $display("[TB] FAIL div_count got %0d want 7", md_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (md_count !== 4'd0 || md_busy !== 1'b0 || stall_cycles !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_mid_div got cnt=%0d busy=%b perf=%0d want 0 0 0", md_count, md_busy, stall_cycles);
    end
    exp_perf = 16'd0;
    tick();
  endtask

  task automatic test_saturation();
    E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
    for (int i = 0; i < 65534; i++) tick();
    n_checks++;
    if (stall_cycles !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sat_before got %h want fffe", stall_cycles); end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_reached got %h want ffff", stall_cycles); end
    tick(); tick(); tick();
    n_checks++;
    if (stall_cycles !== 16'hFFFF || D_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sat_hold got perf=%h stall=%b want ffff 1", stall_cycles, D_stall);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset    = 1'b1;
    exp_perf = 16'd0;
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mult_busy();
    test_div_req();
    test_reset_mid_div();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the five-stage MIPS core.
- Decides each cycle whether the F/D registers freeze and the E register takes a bubble, from Tuse/Tnew register hazards and a busy countdown for the multiply/divide unit.
- Sits beside the D/E/M pipeline registers; its outputs drive their enable and flush inputs.
- Yields to the exception request Req, which flushes the pipeline registers to the 0x00004180 handler PC.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10: busy cycles after a div/divu issues from E.
- CNT_W, 4: width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  rs field of the instruction in D.
- D_rt  in  5  rt field of the instruction in D.
- D_tuse_rs  in  2  cycles until D needs rs; 3 means unused.
- D_tuse_rt  in  2  cycles until D needs rt; 3 means unused.
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register in E; 0 means none.
- E_tnew  in  2  cycles until E's result is forwardable.
- M_A3  in  5  destination register in M.
- M_tnew  in  2  cycles until M's result is forwardable.
- E_md_start  in  1  mult/multu/div/divu is in E this cycle.
- E_md_div  in  1  with E_md_start: 1 = divide, 0 = multiply.
- Req  in  1  exception/interrupt flush request.
- D_stall  out  1  hold PC and the F/D register.
- E_flush  out  1  load a bubble into the E register.
- md_busy  out  1  multiply/divide unit occupied.
- md_count  out  CNT_W  remaining busy cycles.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- All state updates on the posedge of clk.
- Reset: md_count=0 and stall_cycles=0. As a result D_stall=0, E_flush=0 and md_busy=0 while reset is held (inputs idle).
- Busy counter:
  - Reset has highest priority.
  - Otherwise, if E_md_start && !Req: md_count <= E_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise, if md_count != 0: md_count <= md_count - 1.
  - Otherwise hold 0.
- md_busy = E_md_start | (md_count != 0), combinational. The issue cycle therefore counts as busy.
- Req with E_md_start: the start is suppressed, because the younger instruction is squashed. A countdown already in flight continues (its instruction is older and committed).
- stall_rs = (D_rs != 0) && ((E_A3 == D_rs && E_tnew > D_tuse_rs) || (M_A3 == D_rs && M_tnew > D_tuse_rs)).
- stall_rt: same expression with D_rt / D_tuse_rt.
- stall_md = D_is_md && md_busy.
- stall = stall_rs | stall_rt | stall_md.
- Outputs: D_stall = stall && !Req; E_flush = stall && !Req. Both are combinational, with zero latency, in the same cycle as the hazard.
- Req priority: while Req=1, D_stall=0 and E_flush=0. The pipeline registers self-clear via Req.
- Register $0 never causes a stall, even if E_A3 or M_A3 equals 0.
- stall_cycles increments when D_stall=1 and saturates at all-ones; no wrap.
- Reset during a countdown: md_count is 0 on the next cycle. Any in-flight count is discarded.
- A back-to-back md start cannot occur, because D is stalled while md_busy. If E_md_start asserts with md_count != 0, the new start reloads the counter.

Decomposition:
- Shared package cpu_pkg holds:
  - constants MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10, EXC_HANDLER_PC=32'h00004180, RESET_PC=32'h00003000;
  - the 2-bit Tuse/Tnew encoding, with TUSE_NONE=3.
- One natural sub-module: md_busy_counter (load / decrement / busy logic). The hazard compare and the perf counter stay in the top level.

Test Plan:
1. Load-use: E_A3=8, E_tnew=2, D_rs=8, D_tuse_rs=1 -> D_stall=1, E_flush=1. Next cycle, with E_tnew=1 and M_A3=8, M_tnew=1 -> D_stall=0.
2. $0 guard: E_A3=0, E_tnew=2, D_rs=0, D_tuse_rs=0 -> D_stall=0; stall_cycles unchanged.
3. Multiply busy:
   - E_md_start=1, E_md_div=0 at cycle T -> md_count=5 at T+1, then 4, 3, 2, 1, 0 at T+6.
   - With D_is_md=1 held throughout, D_stall=1 for T..T+5 (6 cycles) and 0 at T+6.
4. Divide with Req: E_md_start=1, E_md_div=1, Req=1 in the same cycle -> md_count stays 0, D_stall=0, E_flush=0.
5. Reset mid-divide: start a divide, assert reset at md_count=7 -> md_count=0, md_busy=0 and stall_cycles=0 on the next cycle.
6. Saturation: force 65540 stalled cycles -> stall_cycles reaches 16'hFFFF and stays there.
